// File: rtl/nibble_serial_adder32.sv
// nibble_serial_adder32
//   Multi-cycle adder: one 4-bit carry-lookahead slice is reused once per
//   clock, LSB nibble first, with the slice carry-out held in a register
//   between cycles. A WIDTH-bit add takes WIDTH/4 cycles after the start edge.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request; accepted only in IDLE or DONE
//   a, b     operands, sampled on the accepting edge only
//   ci       carry-in, sampled on the accepting edge only
//   busy     high while nibbles are being processed
//   done     one-cycle pulse; s/co/ovf valid from this cycle onward
//   s        sum a+b+ci mod 2^WIDTH
//   co       unsigned carry-out of the MSB
//   ovf      signed overflow (carry into MSB xor carry out of MSB)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; s/co/ovf hold the last result
// RUN   | one nibble per cycle, cnt selects the nibble
// DONE  | result complete, done pulse; start here chains the next op

module nibble_serial_adder32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  // nibble slice
  logic [CW+1:0] base;
  logic [3:0]    a_nib, b_nib, g, p, sum_nib;
  logic [4:0]    c;

  always_comb begin
    base  = {cnt_q, 2'b00};
    a_nib = a_q[base +: 4];
    b_nib = b_q[base +: 4];
    g     = a_nib & b_nib;
    p     = a_nib | b_nib;
    c[0]  = carry_q;
    // every carry is a flat sum-of-products of g/p and c0, no ripple
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum_nib = a_nib ^ b_nib ^ c[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          s_d     = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[base +: 4] = sum_nib;
        carry_d        = c[4];
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          co_d    = c[4];
          ovf_d   = c[3] ^ c[4];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder32.sv
module tb_nibble_serial_adder32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ci = 1'b0;
  logic        busy, done, co, ovf;
  logic [31:0] s;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];   // {ovf, co, s}

  nibble_serial_adder32 #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic cv);
    logic [32:0] full;
    logic        sov;
    full = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    // signed overflow: operands share a sign that the sum does not
    sov  = (av[31] == bv[31]) && (full[31] != av[31]);
    return {sov, full[32], full[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  // scoreboard monitor: every done pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (reset_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got s=%0h co=%0b ovf=%0b expected no done",
                 s, co, ovf);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({ovf, co, s} !== e) begin
          errors++;
          $display("FAIL result got ovf=%0b co=%0b s=%0h expected ovf=%0b co=%0b s=%0h",
                   ovf, co, s, e[33], e[32], e[31:0]);
        end
      end
    end
  end

  // Issues one op (caller guarantees DUT is IDLE or DONE), then returns in its
  // done cycle. poke>0 pulses start with junk operands mid-run.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        input int poke, output int lat, output int nb);
    a = av; b = bv; ci = cv; start = 1'b1;
    exp_q.push_back(model(av, bv, cv));
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom);
    lat = 0; nb = 0;
    while (!done && lat < 20) begin
      if (busy) nb++;
      if (poke > 0 && lat == poke) begin
        start = 1'b1; a = 32'hDEADBEEF; b = 32'h0BADF00D; ci = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout got no done after %0d cycles expected done", lat);
    end
  endtask

  initial begin
    int lat, nb, nd;
    logic [33:0] last;

    #12;
    chk("reset_state", {busy, done, ovf, co, s}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // carry through every nibble
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, lat, nb);
    chk("carry_all_latency", lat, 8);
    chk("carry_all_busy_cycles", nb, 8);
    chk("carry_all_value", {ovf, co, s}, {1'b0, 1'b1, 32'h0});
    @(posedge clk); #1;

    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, lat, nb);
    chk("ovf_pos_value", {ovf, co, s}, {1'b1, 1'b0, 32'h80000000});
    @(posedge clk); #1;

    run_op(32'h80000000, 32'h80000000, 1'b0, 0, lat, nb);
    chk("ovf_neg_value", {ovf, co, s}, {1'b1, 1'b1, 32'h0});
    @(posedge clk); #1;

    run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 0, lat, nb);
    chk("mixed_ci_value", {ovf, co, s}, {1'b0, 1'b0, 32'hACF13569});
    last = {ovf, co, s};
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", {ovf, co, s}, last);
    chk("idle_flags", {busy, done}, 2'b00);

    // start during RUN is ignored; then chain back-to-back from the done cycle
    run_op(32'h11111111, 32'h22222222, 1'b0, 2, lat, nb);
    chk("poke_latency", lat, 8);
    chk("poke_value", {ovf, co, s}, {1'b0, 1'b0, 32'h33333333});
    run_op(32'd1, 32'd2, 1'b0, 0, lat, nb);
    chk("b2b_latency", lat, 8);
    chk("b2b_busy_cycles", nb, 8);
    chk("b2b_value", s, 32'd3);
    @(posedge clk); #1;
    chk("single_done_pulse", done, 1'b0);

    // reset in the middle of a run
    a = 32'hFFFFFFFF; b = 32'd1; ci = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, ovf, co, s}, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 0, lat, nb);
    chk("after_abort_value", {ovf, co, s}, {1'b0, 1'b1, 32'h0});
    @(posedge clk); #1;

    // random regression, mixing chained and gapped ops
    for (int i = 0; i < 1500; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 0, lat, nb);
      if (lat != 8) chk("rand_latency", lat, 8);
      if ($urandom_range(1, 0) == 0) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
    end
    // a few boundary patterns
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, lat, nb);
    run_op(32'h0, 32'h0, 1'b1, 0, lat, nb);
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 0, lat, nb);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
